// File: rtl/add32_seq_ctrl.sv
// ----------------------------------------------------------------------------
// add32_seq_ctrl
//   Multi-cycle 32-bit add/subtract controller. Two requesters share one
//   16-bit carry-lookahead adder (CLA_16bit). Each operation runs as a low
//   pass and then a high pass. The high pass takes the latched inter-half
//   carry. Requesters are arbitrated round-robin.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_valid/ready/a/b/sub requester 0 operation (sub=1 -> a-b)
//   req1_valid/ready/a/b/sub requester 1 operation
//   resp_valid/ready         result handshake
//   resp_id                  requester that owns the result
//   resp_sum                 32-bit result (modulo 2^32)
//   resp_cout                carry out of bit 31 (no-borrow flag on subtract)
//   resp_ovf                 signed two's-complement overflow
// ----------------------------------------------------------------------------

// 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  gg_s;
  logic [3:0]  pg_s;
  logic [4:0]  cg_s;
  logic [15:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Group generate / propagate for each 4-bit slice
  always_comb begin
    gg_s = 4'b0000;
    pg_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      pg_s[k] = &p_s[4*k +: 4];
    end
  end

  // Second-level lookahead: carry into each group, fully expanded
  always_comb begin
    cg_s    = 5'b00000;
    cg_s[0] = c_in;
    cg_s[1] = gg_s[0] | (pg_s[0] & c_in);
    cg_s[2] = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & c_in);
    cg_s[3] = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
            | (pg_s[2] & pg_s[1] & pg_s[0] & c_in);
    cg_s[4] = gg_s[3] | (pg_s[3] & gg_s[2]) | (pg_s[3] & pg_s[2] & gg_s[1])
            | (pg_s[3] & pg_s[2] & pg_s[1] & gg_s[0])
            | (pg_s[3] & pg_s[2] & pg_s[1] & pg_s[0] & c_in);
  end

  // Carry into each bit, derived from its group carry-in
  always_comb begin
    c_s = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      c_s[4*k]   = cg_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & cg_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & cg_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & cg_s[k]);
    end
  end

  assign sum   = p_s ^ c_s;
  assign c_out = cg_s[4];
endmodule

module add32_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_sum,
  output logic        resp_cout,
  output logic        resp_ovf
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        last_grant_r;
  logic [31:0] a_r;
  logic [31:0] b_r;         // already inverted for subtraction
  logic        cin_r;
  logic        id_r;
  logic        carry_mid_r;
  logic [15:0] sum_lo_r;

  logic        grant0_s;
  logic        grant1_s;
  logic [15:0] add_a_s;
  logic [15:0] add_b_s;
  logic        add_cin_s;
  logic [15:0] add_sum_s;
  logic        add_cout_s;

  // Round-robin arbiter: on a tie the requester that was not served last wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Adder operand mux: low half in LO, high half with the mid carry in HI
  always_comb begin
    add_a_s   = a_r[15:0];
    add_b_s   = b_r[15:0];
    add_cin_s = cin_r;
    case (state_r)
      LO: begin
        add_a_s   = a_r[15:0];
        add_b_s   = b_r[15:0];
        add_cin_s = cin_r;
      end
      HI: begin
        add_a_s   = a_r[31:16];
        add_b_s   = b_r[31:16];
        add_cin_s = carry_mid_r;
      end
      default: begin
        add_a_s   = a_r[15:0];
        add_b_s   = b_r[15:0];
        add_cin_s = cin_r;
      end
    endcase
  end

  CLA_16bit u_cla (
    .a     (add_a_s),
    .b     (add_b_s),
    .c_in  (add_cin_s),
    .sum   (add_sum_s),
    .c_out (add_cout_s)
  );

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      a_r          <= 32'h0000_0000;
      b_r          <= 32'h0000_0000;
      cin_r        <= 1'b0;
      id_r         <= 1'b0;
      carry_mid_r  <= 1'b0;
      sum_lo_r     <= 16'h0000;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_sum     <= 32'h0000_0000;
      resp_cout    <= 1'b0;
      resp_ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s) begin
            a_r     <= req0_a;
            b_r     <= req0_sub ? ~req0_b : req0_b;
            cin_r   <= req0_sub;
            id_r    <= 1'b0;
            state_r <= LO;
          end else if (grant1_s) begin
            a_r     <= req1_a;
            b_r     <= req1_sub ? ~req1_b : req1_b;
            cin_r   <= req1_sub;
            id_r    <= 1'b1;
            state_r <= LO;
          end else begin
            state_r <= IDLE;
          end
        end
        LO: begin
          sum_lo_r    <= add_sum_s;
          carry_mid_r <= add_cout_s;
          state_r     <= HI;
        end
        HI: begin
          resp_sum   <= {add_sum_s, sum_lo_r};
          resp_cout  <= add_cout_s;
          // Overflow: operands agree in sign but the result sign differs
          resp_ovf   <= (a_r[31] == b_r[31]) && (add_sum_s[15] != a_r[31]);
          resp_id    <= id_r;
          resp_valid <= 1'b1;
          state_r    <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            last_grant_r <= id_r;
            resp_valid   <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/add32_seq_ctrl.md
# add32_seq_ctrl

Multi-cycle 32-bit add/subtract controller that time-shares one 16-bit carry-lookahead adder (`CLA_16bit`, instantiated inside this block) between two requesters. It arbitrates round-robin, runs each 32-bit operation as two 16-bit passes (low half, then high half with the latched inter-half carry), and returns sum, carry-out and signed overflow through a valid/ready response port. It sits between the miniRISC execute-stage requesters (ALU and address generation) and the shared adder.

## Interface

- Parameters: none. Operand width is fixed at 32; the adder slice is fixed at 16.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`  in  32  operand A.
- `req0_b`  in  32  operand B.
- `req0_sub`  in  1  1 = A−B, 0 = A+B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0, for requester 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_id`  out  1  index of the requester that owns the result.
- `resp_sum`  out  32  result.
- `resp_cout`  out  1  carry out of bit 31. For subtraction this is the no-borrow flag: 1 when A ≥ B unsigned.
- `resp_ovf`  out  1  signed two's-complement overflow.

## Operation

- FSM states: IDLE, LO, HI, DONE.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester.
  - Priority goes to the requester other than `last_grant`. A lone valid requester is always granted.
  - `reqN_ready` = 1 combinationally for the granted requester only.
  - On handshake, latch A, B' = sub ? ~B : B, cin = sub, and id. Go to LO.
- **LO**
  - Adder inputs: A[15:0], B'[15:0], cin.
  - Latch sum[15:0] and carry_mid = adder c_out. Go to HI.
- **HI**
  - Adder inputs: A[31:16], B'[31:16], carry_mid.
  - Latch sum[31:16] and `resp_cout` = adder c_out.
  - `resp_ovf` = (A[31] == B'[31]) && (sum[31] != A[31]).
  - Go to DONE.
- **DONE**
  - `resp_valid` = 1, with all resp_* outputs stable.
  - When `resp_ready` = 1: set `last_grant` = id and go to IDLE.
- `reqN_ready` is 0 in every state except IDLE. No new request is accepted while an operation is in flight or a result is waiting.
- A requester must hold its valid and operands stable until it sees ready. Its operand bits are ignored after the handshake.
- Arithmetic is modulo 2^32. Inputs carry no sign or width extension.

## Timing

- Reset values:
  - state = IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `resp_valid` = 0, `resp_sum` = 0, `resp_cout` = 0, `resp_ovf` = 0, `resp_id` = 0.
  - `req0_ready` = `req1_ready` = 0 while `rst` is high.
- Latency: a handshake at cycle T gives `resp_valid` = 1 at cycle T+3.
- Throughput: best case one operation every 4 cycles (IDLE, LO, HI, DONE with `resp_ready` already high).
- Backpressure: DONE holds indefinitely while `resp_ready` = 0, with no change to any output.
- After the response handshake, the next grant happens in the following cycle (IDLE). Results are never dropped or overwritten.
- Simultaneous `req0_valid` and `req1_valid` held continuously: grants alternate 0, 1, 0, 1, …
- Reset mid-operation (`rst` in LO, HI or DONE):
  - Next cycle: IDLE with all outputs at reset values; the in-flight operation is discarded with no response.
  - A requester still holding valid is re-accepted from scratch, with requester 0 priority.

## Test plan

- Reset, then req0 add 0x0000FFFF + 0x00000001, accepted at T → at T+3: `resp_valid` = 1, sum 0x00010000, cout 0, ovf 0, id 0. This checks the inter-half carry.
- Additions:
  - 0x7FFFFFFF + 0x00000001 → 0x80000000, cout 0, ovf 1.
  - 0xFFFFFFFF + 0x00000001 → 0x00000000, cout 1, ovf 0.
- Subtractions:
  - 0x00000000 − 0x00000001 → 0xFFFFFFFF, cout 0, ovf 0.
  - 0x80000000 − 0x00000001 → 0x7FFFFFFF, cout 1, ovf 1.
  - 0x12345678 − 0x12345678 → 0, cout 1, ovf 0.
- req0 and req1 valid every cycle with distinct operands, `resp_ready` = 1 → accepts spaced 4 cycles apart, `resp_id` sequence 0, 1, 0, 1, and each sum matches its own requester's operands.
- `resp_ready` held low for 5 cycles in DONE → `resp_valid` and data stable, both ready lines 0. Raise `resp_ready` → next cycle IDLE, and a pending request is accepted that cycle.
- `rst` pulsed for 1 cycle while in HI, req1 holding valid → no response is emitted. After reset, req1 is accepted in the first IDLE cycle and its result arrives 3 cycles later, correct.
